// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter.
// Bit timing is counted in clk_en ticks, OVERSAMPLE per bit.
module uart_tx #(
   parameter int FIFO_DEPTH = 4,
   parameter int OVERSAMPLE = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clk_en,
   input  logic [7:0]                       dout,
   input  logic                             send,
   output logic                             tx,
   output logic                             busy,
   output logic                             full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full_q;
   logic          avail_q;
   logic          have_data;
   logic          push;
   logic          pop;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          tick_wrap;

   // A write is accepted only while there is room, even if a pop frees one.
   assign push      = send & ~full_q;
   // avail_q lags count by one edge, giving the two-edge send-to-start latency.
   assign have_data = avail_q & (count_q != '0);
   assign tick_wrap = (tick_q == TICK_LAST);

   // FIFO occupancy next-state from the push/pop pair.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage is left unreset; only pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dout;
      end
   end

   // FIFO pointers, count and registered flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         avail_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == CNT_FULL);
         avail_q <= (count_q != '0);
      end
   end

   // Frame sequencer: next state, tick/bit counters and next tx level.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (clk_en && have_data) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tick_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (clk_en) begin
               if (tick_wrap) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
                  state_d = DATA;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         DATA: begin
            if (clk_en) begin
               if (tick_wrap) begin
                  tick_d = '0;
                  if (bit_q == 3'd7) begin
                     bit_d   = '0;
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     tx_d    = shift_q[0];
                     shift_d = {1'b0, shift_q[7:1]};
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         STOP: begin
            if (clk_en) begin
               if (tick_wrap) begin
                  tick_d = '0;
                  if (have_data) begin
                     pop     = 1'b1;
                     shift_d = mem_q[rd_ptr_q];
                     tx_d    = 1'b0;
                     state_d = START;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers; tx comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign tx    = tx_q;
   assign full  = full_q;
   assign count = count_q;
   assign busy  = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, FIFO and reset,
// plus a loopback through a simple bench-side receiver.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst;
   logic       clk_en;
   logic [7:0] dout = 8'h00;
   logic       send = 1'b0;
   logic       tx;
   logic       busy;
   logic       full;
   logic [2:0] count;

   int n_checks = 0;
   int n_fail = 0;

   int en_div = 0;
   int phase = 0;
   logic cap [400];

   uart_tx #(
      .FIFO_DEPTH(4),
      .OVERSAMPLE(8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .clk_en(clk_en),
      .dout  (dout),
      .send  (send),
      .tx    (tx),
      .busy  (busy),
      .full  (full),
      .count (count)
   );

   always #5 if (clk_run) clk = ~clk;

   assign clk_en = (en_div == 1) || (en_div == 3 && phase == 0);

   always @(negedge clk) phase <= (phase == 2) ? 0 : phase + 1;

   // bench-side receiver: samples mid-bit, 8 clocks per bit
   logic       rx_on = 1'b0;
   int         rx_st = 0;
   int         rx_cnt = 0;
   logic       rx_bad = 1'b0;
   logic [7:0] rx_sh = 8'h00;
   logic [7:0] rx_data [32];
   logic       rx_errs [32];
   int         rx_n = 0;

   always @(posedge clk) begin
      if (!rx_on) begin
         rx_st <= 0;
      end else if (rx_st == 0) begin
         if (tx === 1'b0) begin
            rx_st  <= 1;
            rx_cnt <= 1;
            rx_bad <= 1'b0;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt % 8 == 4) begin
            if (rx_cnt / 8 == 0) begin
               if (tx !== 1'b0) rx_bad <= 1'b1;
            end else if (rx_cnt / 8 <= 8) begin
               rx_sh[rx_cnt/8-1] <= tx;
            end else begin
               if (rx_n < 32) begin
                  rx_data[rx_n] <= rx_sh;
                  rx_errs[rx_n] <= rx_bad | (tx !== 1'b1);
               end
               rx_n  <= rx_n + 1;
               rx_st <= 0;
            end
         end
      end
   end

   function automatic logic fbit(input logic [7:0] b, input int p);
      if (p == 0) return 1'b0;
      if (p >= 9) return 1'b1;
      return b[p-1];
   endfunction

   task automatic capture(input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge clk);
         @(negedge clk);
         cap[j] = tx;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #5;
      n_checks++;
      if (tx !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_tx got %b want 1", tx);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_busy got %b want 0", busy);
      end
      n_checks++;
      if (full !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_full got %b want 0", full);
      end
      n_checks++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL rst_count got %0d want 0", count);
      end
      clk_run = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      logic e;
      en_div = 1;
      @(negedge clk);
      dout = 8'hA5;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      n_checks++;
      if (tx !== 1'b1 || count !== 3'd1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_e0 got tx=%b cnt=%0d busy=%b want 1/1/1",
                  tx, count, busy);
      end
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin
         n_fail++;
         $display("FAIL single_e1_tx got %b want 1", tx);
      end
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b0 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL single_e2 got tx=%b cnt=%0d want 0/0", tx, count);
      end
      capture(79);
      for (int j = 0; j < 79; j++) begin
         e = fbit(8'hA5, (j + 1) / 8);
         n_checks++;
         if (cap[j] !== e) begin
            n_fail++;
            $display("FAIL single_bit k=%0d got %b want %b", j + 1, cap[j], e);
         end
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL single_end got busy=%b tx=%b want 0/1", busy, tx);
      end
   endtask

   task automatic test_fill;
      logic [7:0] fb [5];
      logic e;
      int k;
      fb[0] = 8'h00;
      fb[1] = 8'hFF;
      fb[2] = 8'h55;
      fb[3] = 8'h3C;
      fb[4] = 8'h99;
      en_div = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 4) begin
            n_checks++;
            if (full !== 1'b1 || count !== 3'd4) begin
               n_fail++;
               $display("FAIL fill_4th got full=%b cnt=%0d want 1/4",
                        full, count);
            end
         end
         dout = fb[i];
         send = 1'b1;
      end
      @(negedge clk);
      send = 1'b0;
      n_checks++;
      if (full !== 1'b1 || count !== 3'd4 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_drop got full=%b cnt=%0d tx=%b want 1/4/1",
                  full, count, tx);
      end
      en_div = 1;
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_start got %b want 0", tx);
      end
      capture(319);
      for (int j = 0; j < 319; j++) begin
         k = j + 1;
         e = fbit(fb[k/80], (k % 80) / 8);
         n_checks++;
         if (cap[j] !== e) begin
            n_fail++;
            $display("FAIL fill_bit k=%0d got %b want %b", k, cap[j], e);
         end
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tx !== 1'b1 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL fill_end got busy=%b tx=%b cnt=%0d want 0/1/0",
                  busy, tx, count);
      end
   endtask

   task automatic test_gating;
      logic e;
      en_div = 3;
      @(negedge clk);
      dout = 8'h01;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      for (int w = 0; w < 40 && tx !== 1'b0; w++) @(negedge clk);
      n_checks++;
      if (tx !== 1'b0) begin
         n_fail++;
         $display("FAIL gate_start got %b want 0 (timeout)", tx);
      end
      capture(239);
      for (int j = 0; j < 239; j++) begin
         e = fbit(8'h01, (j + 1) / 24);
         n_checks++;
         if (cap[j] !== e) begin
            n_fail++;
            $display("FAIL gate_bit k=%0d got %b want %b", j + 1, cap[j], e);
         end
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL gate_end got busy=%b tx=%b want 0/1", busy, tx);
      end
      en_div = 1;
   endtask

   task automatic test_reset_mid;
      logic low;
      en_div = 1;
      @(negedge clk);
      dout = 8'h11;
      send = 1'b1;
      @(negedge clk);
      dout = 8'h22;
      @(negedge clk);
      dout = 8'h33;
      @(negedge clk);
      send = 1'b0;
      n_checks++;
      if (tx !== 1'b0 || count !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_pre got tx=%b cnt=%0d want 0/2", tx, count);
      end
      repeat (35) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (tx !== 1'b1 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL mid_rst got tx=%b cnt=%0d want 1/0", tx, count);
      end
      n_checks++;
      if (busy !== 1'b0 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst_flags got busy=%b full=%b want 0/0",
                  busy, full);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      low = 1'b0;
      repeat (150) begin
         @(negedge clk);
         if (tx !== 1'b1) low = 1'b1;
      end
      n_checks++;
      if (low !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_after got low=%b busy=%b want 0/0", low, busy);
      end
   endtask

   task automatic test_loopback;
      logic [7:0] sb [32];
      int sent;
      en_div = 1;
      for (int i = 0; i < 32; i++) sb[i] = 8'($urandom_range(0, 255));
      @(negedge clk);
      rx_on = 1'b1;
      sent = 0;
      for (int c = 0; c < 4000 && sent < 32; c++) begin
         @(negedge clk);
         if (full === 1'b0) begin
            dout = sb[sent];
            send = 1'b1;
            sent++;
         end else begin
            send = 1'b0;
         end
      end
      @(negedge clk);
      send = 1'b0;
      for (int w = 0; w < 4000 && rx_n < 32; w++) @(negedge clk);
      n_checks++;
      if (rx_n != 32) begin
         n_fail++;
         $display("FAIL loop_count got %0d want 32", rx_n);
      end
      for (int i = 0; i < 32 && i < rx_n; i++) begin
         n_checks++;
         if (rx_data[i] !== sb[i] || rx_errs[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_byte %0d got %h err=%b want %h err=0",
                     i, rx_data[i], rx_errs[i], sb[i]);
         end
      end
      rx_on = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_fill;
      test_gating;
      test_reset_mid;
      test_loopback;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving transmit FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter OVERSAMPLE, default 8, giving clk_en ticks per serial bit; must match uart_rx over-8 sampling.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clk_en, input, 1, oversample tick; bit timing advances only on cycles where clk_en=1.
REQ-006 SHALL have port dout, input, 8, byte to transmit; sampled when send=1.
REQ-007 SHALL have port send, input, 1, single-cycle write strobe into the FIFO.
REQ-008 SHALL have port tx, output, 1, registered serial line; idle high.
REQ-009 SHALL have port busy, output, 1, high when the FIFO is non-empty or a frame is in progress.
REQ-010 SHALL have port full, output, 1, registered; high when FIFO count equals FIFO_DEPTH.
REQ-011 SHALL have port count, output, $clog2(FIFO_DEPTH+1), number of bytes queued, excluding the byte being shifted.

Function
REQ-012 SHALL push dout into the FIFO on any edge with send=1 and full=0, independent of clk_en.
REQ-013 SHALL silently drop send while full=1, even when a pop occurs in the same cycle; FIFO contents and count stay unchanged.
REQ-014 SHALL, on a same-cycle push and pop, perform both operations and leave count unchanged.
REQ-015 SHALL implement read/write pointers with wrap-around modulo FIFO_DEPTH, using count for full/empty detection.
REQ-016 SHALL implement FSM states IDLE, START, DATA and STOP, with a tick counter 0..OVERSAMPLE-1 and a bit index 0..7.
REQ-017 SHALL, in IDLE with clk_en=1 and FIFO non-empty, pop the head entry into the shift register, clear the tick counter, drive tx=0 and enter START.
REQ-018 SHALL increment the tick counter only on clk_en=1, and hold each state for exactly OVERSAMPLE ticks.
REQ-019 SHALL leave START for DATA, driving bit 0 (LSB first).
REQ-020 SHALL, in DATA, advance through bits 0..7 at each tick-counter wrap; after bit 7 it SHALL drive tx=1 and enter STOP.
REQ-021 SHALL, at the end of STOP, go directly to START with the next popped byte if the FIFO is non-empty, leaving no idle gap; otherwise it SHALL enter IDLE.
REQ-022 SHALL produce a frame of exactly 10*OVERSAMPLE clk_en ticks: 1 start bit, 8 data bits, 1 stop bit, no parity.
REQ-023 SHALL, with clk_en held at 1 and the FIFO empty in IDLE, drop tx on the second rising edge after the edge that samples send=1.
REQ-024 SHALL keep tx glitch-free by driving it directly from a flop.
REQ-025 SHALL leave timing unaffected by dout/send activity during a frame, apart from the FIFO push.
REQ-026 SHALL deassert busy on the same edge that returns the FSM to IDLE with the FIFO empty.

Reset
REQ-027 SHALL, on rst=1 and asynchronously, set tx=1, busy=0, full=0 and count=0, empty the FIFO, and put the FSM in IDLE with tick counter and bit index at 0.
REQ-028 SHALL abort any frame in progress on reset without completing it; no queued byte SHALL be transmitted after reset release.
REQ-029 SHALL leave FIFO storage contents unconstrained under reset.

Verification
REQ-030 The bench SHALL check reset: assert rst with no clock -> tx=1, busy=0, full=0, count=0.
REQ-031 The bench SHALL check a single byte: clk_en=1, write 0xA5 -> tx=0 for 8 cycles, then 1,0,1,0,0,1,0,1 for 8 cycles each, then 1 for 8 cycles; busy=0 after 80 cycles.
REQ-032 The bench SHALL check fill and overflow: with clk_en=0, write 0x00, 0xFF, 0x55, 0x3C, 0x99 on consecutive cycles -> full=1 after the 4th write, count=4, 0x99 dropped. Then set clk_en=1 -> four contiguous frames totalling 320 cycles, with no high gap between stop and start bits.
REQ-033 The bench SHALL check clk_en gating: pulse clk_en every 3rd cycle, write 0x01 -> each bit lasts 24 cycles and the frame lasts 240 cycles.
REQ-034 The bench SHALL check reset mid-frame: assert rst during data bit 3 with 2 bytes queued -> tx=1 immediately, count=0, and tx stays high after release.
REQ-035 The bench SHALL check loopback: connect tx to uart_rx rx, both with clk_en=1, and send 32 random bytes -> every recv shows din equal to the sent byte with err=0.
